// File: rtl/exec_mem_responder.sv
// exec_mem_responder: byte-addressed packet/action memory between the packet
// ingress/egress path and the action executor.
//
// A packet arrives as a byte stream (load_*) and is written from LOAD_BASE
// upward. The executor then reads and writes the memory through a big-endian,
// 1..4 byte wide request port (mem_*), with one cycle of read latency. A dump
// request (dump_start_i) streams the possibly modified packet back out (dump_*).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mem_ce_i/we_i     executor request enable / write select
//   mem_addr_i        executor byte address (32 bit, never wraps)
//   mem_width_i       access width in bytes, 1..4 valid
//   mem_data_i/o      right-aligned write data / registered read data
//   mem_busy_o        high while the executor port is not being served
//   load_valid_i, load_data_i, load_last_i, load_ready_o   ingress stream
//   dump_start_i      begin draining the packet
//   dump_valid_o, dump_data_o, dump_last_o, dump_ready_i   egress stream
//   pkt_len_o         length of the last loaded packet (saturates at 0xFFFF)
//   overflow_o        ingress ran past the memory; sticky until next load

module exec_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LOAD_BASE   = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_width_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_busy_o,

    input  logic        load_valid_i,
    input  logic [7:0]  load_data_i,
    input  logic        load_last_i,
    output logic        load_ready_o,

    input  logic        dump_start_i,
    output logic        dump_valid_o,
    output logic [7:0]  dump_data_o,
    output logic        dump_last_o,
    input  logic        dump_ready_i,

    output logic [15:0] pkt_len_o,
    output logic        overflow_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_BYTES);
    // Bytes available between LOAD_BASE and the end of memory.
    localparam int unsigned CAP    = DEPTH_BYTES - LOAD_BASE;

    typedef logic [ADDR_W:0] len_t;

    typedef enum logic [1:0] {
        StIdle,
        StReady,
        StDump
    } state_t;

    logic [7:0] mem [DEPTH_BYTES];

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pkt_len_q, pkt_len_d;
    logic        overflow_q, overflow_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        dump_valid_q, dump_valid_d;
    logic [7:0]  dump_data_q, dump_data_d;
    logic        dump_last_q, dump_last_d;
    len_t        dptr_q, dptr_d;
    len_t        dump_len_q, dump_len_d;

    logic              load_ready;
    logic              load_accept;
    logic [32:0]       ing_addr;
    logic              ing_in_range;
    logic              ing_we;
    logic [ADDR_W-1:0] ing_idx;

    logic              width_ok;
    logic              ex_req;
    logic [31:0]       rdata;
    logic [32:0]       ex_addr;
    logic              ex_we    [4];
    logic [ADDR_W-1:0] ex_idx   [4];
    logic [7:0]        ex_wdata [4];

    // Addresses are carried in 33 bits so addr+3 never wraps back into range.
    function automatic logic [7:0] rd_byte(input logic [32:0] a);
        if (a < 33'(DEPTH_BYTES)) begin
            return mem[a[ADDR_W-1:0]];
        end
        return 8'h00;
    endfunction

    assign load_ready   = (state_q == StIdle) && !rst;
    assign load_accept  = load_valid_i && load_ready;
    assign ing_addr     = 33'(LOAD_BASE) + 33'(cnt_q);
    assign ing_in_range = ing_addr < 33'(DEPTH_BYTES);
    assign ing_idx      = ing_addr[ADDR_W-1:0];

    assign width_ok = (mem_width_i != 4'd0) && (mem_width_i <= 4'd4);
    assign ex_req   = (state_q == StReady) && mem_ce_i && !rst;

    // Executor datapath: big-endian gather for reads, scatter for writes.
    always_comb begin
        rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ex_addr     = {1'b0, mem_addr_i} + 33'(i);
            ex_we[i]    = 1'b0;
            ex_idx[i]   = ex_addr[ADDR_W-1:0];
            ex_wdata[i] = 8'h00;
            if (i < int'(mem_width_i)) begin
                rdata       = {rdata[23:0], rd_byte(ex_addr)};
                ex_wdata[i] = 8'(mem_data_i >> (8 * (int'(mem_width_i) - 1 - i)));
                ex_we[i]    = ex_req && mem_we_i && width_ok &&
                              (ex_addr < 33'(DEPTH_BYTES));
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pkt_len_d    = pkt_len_q;
        overflow_d   = overflow_q;
        mem_data_d   = mem_data_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        dump_last_d  = dump_last_q;
        dptr_d       = dptr_q;
        dump_len_d   = dump_len_q;
        ing_we       = 1'b0;

        // Executor read result; writes and idle cycles leave it untouched.
        if (mem_ce_i) begin
            if (state_q != StReady) begin
                mem_data_d = 32'h0;
            end else if (!mem_we_i) begin
                mem_data_d = width_ok ? rdata : 32'h0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (load_accept) begin
                    ing_we     = ing_in_range;
                    // First byte of a new load clears the sticky flag.
                    overflow_d = ((cnt_q == 16'd0) ? 1'b0 : overflow_q) | !ing_in_range;
                    if (load_last_i) begin
                        pkt_len_d = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
                        cnt_d     = 16'd0;
                        state_d   = StReady;
                    end else begin
                        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    end
                end
            end

            StReady: begin
                if (dump_start_i) begin
                    state_d      = StDump;
                    dptr_d       = '0;
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                    dump_len_d   = (32'(pkt_len_q) < CAP) ? len_t'(pkt_len_q) : len_t'(CAP);
                end
            end

            StDump: begin
                // Advance only when the output register is empty or being drained.
                if (!dump_valid_q || dump_ready_i) begin
                    if (dump_valid_q && dump_last_q) begin
                        dump_valid_d = 1'b0;
                        dump_last_d  = 1'b0;
                        state_d      = StIdle;
                    end else if (dptr_q < dump_len_q) begin
                        dump_valid_d = 1'b1;
                        dump_data_d  = rd_byte(33'(LOAD_BASE) + 33'(dptr_q));
                        dump_last_d  = (dptr_q == dump_len_q - len_t'(1));
                        dptr_d       = dptr_q + len_t'(1);
                    end else begin
                        // Nothing to send (empty packet).
                        dump_valid_d = 1'b0;
                        state_d      = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 16'd0;
            pkt_len_q    <= 16'd0;
            overflow_q   <= 1'b0;
            mem_data_q   <= 32'h0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= 8'h00;
            dump_last_q  <= 1'b0;
            dptr_q       <= '0;
            dump_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pkt_len_q    <= pkt_len_d;
            overflow_q   <= overflow_d;
            mem_data_q   <= mem_data_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            dump_last_q  <= dump_last_d;
            dptr_q       <= dptr_d;
            dump_len_q   <= dump_len_d;
        end
    end

    // Storage is never cleared; ingress and executor writes are exclusive by state.
    always_ff @(posedge clk) begin
        if (ing_we) begin
            mem[ing_idx] <= load_data_i;
        end
        for (int i = 0; i < 4; i++) begin
            if (ex_we[i]) begin
                mem[ex_idx[i]] <= ex_wdata[i];
            end
        end
    end

    assign mem_data_o   = mem_data_q;
    assign mem_busy_o   = (state_q != StReady);
    assign load_ready_o = load_ready;
    assign dump_valid_o = dump_valid_q;
    assign dump_data_o  = dump_data_q;
    assign dump_last_o  = dump_last_q;
    assign pkt_len_o    = pkt_len_q;
    assign overflow_o   = overflow_q;

endmodule

// File: doc/exec_mem_responder.md
Name: exec_mem_responder

Overview:
- Byte-addressed packet/action memory that answers the executor-side memory request interface (ce/we/addr/width/data, one-cycle read latency).
- Ingress side: a byte stream loads a packet into the memory.
- Egress side: after processing, a dump stream drains the (possibly modified) packet out.
- Sits between the packet ingress/egress path and the action executor.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes. Power of two, at least 64.
- LOAD_BASE, 0: byte address where ingress byte 0 is written and where the dump starts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_ce_i  in  1  request enable
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  byte address
- mem_width_i  in  4  access width in bytes; 1..4 are valid
- mem_data_i  in  32  write data, right-aligned
- mem_data_o  out  32  read data, right-aligned, registered
- mem_busy_o  out  1  1 = executor port not being served (state is not READY)
- load_valid_i  in  1  ingress byte valid
- load_data_i  in  8  ingress byte
- load_last_i  in  1  final ingress byte
- load_ready_o  out  1  ingress may transfer
- dump_start_i  in  1  begin egress drain
- dump_valid_o  out  1  egress byte valid, registered
- dump_data_o  out  8  egress byte
- dump_last_o  out  1  final egress byte
- dump_ready_i  in  1  egress sink accepts the byte
- pkt_len_o  out  16  latched packet length in bytes
- overflow_o  out  1  ingress exceeded capacity; sticky until the next load begins

Behaviour:
- Reset values: mem_data_o=0, dump_valid_o=0, dump_data_o=0, dump_last_o=0, pkt_len_o=0, overflow_o=0. State goes to IDLE. Memory contents are not cleared.
- load_ready_o = (state==IDLE) and not rst.
- mem_busy_o = (state!=READY).
- Reset mid-load or mid-dump aborts the operation immediately and returns to IDLE.
- State machine:
  - IDLE: each accepted byte (load_valid_i & load_ready_o) is written to LOAD_BASE+cnt, then cnt increments.
  - IDLE: on the first accepted byte, overflow_o clears.
  - IDLE: on an accepted byte with load_last_i=1, pkt_len_o <= cnt+1 (counting accepted bytes, including dropped ones, saturating at 0xFFFF), then cnt clears and the state goes to READY.
  - IDLE, overflow: a byte whose address is >= DEPTH_BYTES is dropped and sets overflow_o. Acceptance continues until last.
  - READY: the executor port is served. dump_start_i=1 moves to DUMP. Executor requests in the same cycle as dump_start_i are still served.
  - DUMP: streams min(pkt_len_o, DEPTH_BYTES-LOAD_BASE) bytes starting at LOAD_BASE.
  - DUMP: dump_valid_o rises no later than 2 cycles after dump_start_i is sampled.
  - DUMP: data/last hold stable while valid & !ready.
  - DUMP: with dump_ready_i held high, throughput is 1 byte/cycle after the first byte.
  - DUMP: dump_last_o is high with the final byte. On the final handshake, dump_valid_o drops on the next cycle and the state goes to IDLE.
- Executor port, big-endian: byte at addr is the most significant of the width bytes.
- Read, ce=1, we=0, width w in 1..4: on the next cycle mem_data_o = {zeros, M[addr], ..., M[addr+w-1]}. Bytes at addresses >= DEPTH_BYTES read as 0. No 32-bit address wrap.
- Write, ce=1, we=1, width w: M[addr+i] <= mem_data_i[8(w-i)-1 : 8(w-i-1)] for i=0..w-1. Bytes beyond DEPTH_BYTES are dropped. mem_data_o holds its previous value.
- Width 0 or >4: no memory change. A read returns 0.
- ce=0: mem_data_o holds its last value.
- Back-to-back requests: one per cycle. A read in the cycle after a write to the same bytes returns the new data.
- When mem_busy_o=1: requests are ignored, and mem_data_o is 0 on the cycle following any ce.

Test Plan:
- Load 0x45,0x00,0x00,0x54 (last on byte 4) -> pkt_len_o=4, READY. Read addr 0 width 4 -> mem_data_o=0x45000054 one cycle after ce. Read addr 1 width 2 -> 0x00000000.
- In READY: write addr 2 width 2 data 0x0000BEEF, then read addr 0 width 4 on the next cycle -> 0x4500BEEF. Read width 1 addr 3 -> 0x000000EF.
- Reads at addr DEPTH_BYTES-2 width 4 after writing 0xAABB there -> 0xAABB0000. Write width 0 -> no change. Read width 5 -> 0.
- Dump the 4-byte packet with dump_ready_i toggling 1,0,1,1,1 -> bytes 45,00,BE,EF each held while not ready. dump_last_o only with EF. Then IDLE, load_ready_o=1.
- Load DEPTH_BYTES+3 bytes -> overflow_o=1, pkt_len_o=DEPTH_BYTES+3. Dump emits exactly DEPTH_BYTES bytes. The next load's first byte clears overflow_o.
- Assert rst for 1 cycle mid-dump after 2 bytes -> dump_valid_o=0 and pkt_len_o=0 next cycle, mem_busy_o=1, load_ready_o=1. Executor ce in IDLE -> mem_data_o=0.
